// File: rtl/audio_clock_regeneration_packet_gen_pkg.sv
// HDMI ACR shared types: rate codes, N / wrap tables, FSM states and subpacket builder.
// Pure definitions, no logic; imported by the meter and the packet generator top.
package hdmi_acr_pkg;

  typedef enum logic [2:0] {
    RATE_32K   = 3'd0,
    RATE_44K1  = 3'd1,
    RATE_48K   = 3'd2,
    RATE_88K2  = 3'd3,
    RATE_96K   = 3'd4,
    RATE_176K4 = 3'd5,
    RATE_192K  = 3'd6,
    RATE_RSVD  = 3'd7
  } acr_rate_e;

  // Reserved code decodes as 48 kHz.
  localparam logic [19:0] N_TABLE [0:7] = '{
    20'd4096, 20'd6272, 20'd6144, 20'd12544, 20'd12288, 20'd25088, 20'd24576, 20'd6144
  };

  localparam logic [7:0] WRAP_LEN_TABLE [0:7] = '{
    8'd32, 8'd49, 8'd48, 8'd98, 8'd96, 8'd196, 8'd192, 8'd48
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } acr_state_e;

  localparam logic [23:0] ACR_HEADER = 24'h000001;

  function automatic logic [55:0] acr_subpacket(input logic [19:0] n, input logic [19:0] cts);
    return {n[7:0], n[15:8], 4'd0, n[19:16], cts[7:0], cts[15:8], 4'd0, cts[19:16], 8'd0};
  endfunction

endpackage

// File: rtl/audio_clock_regeneration_packet_gen_cts_meter.sv
// CTS meter: counts audio ticks to N/128, measures pixel cycles between wraps, flags timeout.
// Wrap/measurement/timeout are combinational from registered counters; no backpressure.
module acr_cts_meter
  import hdmi_acr_pkg::*;
#(
  parameter int CTS_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = (2**CTS_WIDTH) - 2
) (
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  input  logic                 i_restart,
  input  logic                 i_tick,
  input  logic [7:0]           i_wrap_len,
  output logic                 o_wrap,
  output logic [CTS_WIDTH-1:0] o_meas,
  output logic                 o_timeout
);

  localparam logic [CTS_WIDTH-1:0] LP_TIMEOUT_M1 = CTS_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [7:0]           r_smp_cnt;
  logic [CTS_WIDTH-1:0] r_cyc_cnt;
  logic                 w_wrap;

  // >= keeps the wrap robust should the count ever sit above the window length.
  assign w_wrap    = i_tick && (r_smp_cnt >= (i_wrap_len - 8'd1));
  assign o_wrap    = w_wrap;
  assign o_meas    = r_cyc_cnt + CTS_WIDTH'(1);
  // Fires on the cycle whose edge would bring the count to TIMEOUT_CYCLES.
  assign o_timeout = !w_wrap && !i_restart && (r_cyc_cnt == LP_TIMEOUT_M1);

  always_ff @(posedge clk_pixel) begin
    if (!reset_n || i_restart) begin
      r_smp_cnt <= '0;
      r_cyc_cnt <= '0;
    end else begin
      if (w_wrap) begin
        r_smp_cnt <= '0;
      end else if (i_tick) begin
        r_smp_cnt <= r_smp_cnt + 8'd1;
      end
      if (w_wrap) begin
        r_cyc_cnt <= '0;
      end else if (r_cyc_cnt != '1) begin
        r_cyc_cnt <= r_cyc_cnt + CTS_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/audio_clock_regeneration_packet_gen.sv
// ACR packet source: lock FSM, optional CTS averaging (ACR_CTS_AVERAGE_EN), ready/ack handshake.
// 1-cycle latency from wrap to packet_ready/cts_value; packet held pending until packet_ack.
module audio_clock_regeneration_packet_gen
  import hdmi_acr_pkg::*;
#(
  parameter int VIDEO_RATE     = 25200000,
  parameter int CTS_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = (2**CTS_WIDTH) - 2
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic [2:0]  rate_sel,
  input  logic        packet_ack,
  output logic        packet_ready,
  output logic        locked,
  output logic [19:0] n_value,
  output logic [19:0] cts_value,
  output logic [23:0] header,
  output logic [55:0] sub [3:0]
);

  acr_state_e           r_state;
  logic [2:0]           r_rate;
  logic [19:0]          r_n;
  logic [19:0]          r_pkt_n;
  logic [CTS_WIDTH-1:0] r_cts;
  logic                 r_pending;
  logic                 r_locked;

  logic                 w_rate_chg;
  logic                 w_wrap;
  logic                 w_timeout;
  logic [CTS_WIDTH-1:0] w_meas;
  logic [CTS_WIDTH-1:0] w_load_cts;
  logic                 w_hist_full;
  logic                 w_load;

  assign w_rate_chg = (rate_sel != r_rate);

  acr_cts_meter #(
    .CTS_WIDTH      (CTS_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_meter (
    .clk_pixel  (clk_pixel),
    .reset_n    (reset_n),
    .i_restart  (w_rate_chg),
    .i_tick     (sample_tick),
    .i_wrap_len (WRAP_LEN_TABLE[r_rate]),
    .o_wrap     (w_wrap),
    .o_meas     (w_meas),
    .o_timeout  (w_timeout)
  );

`ifdef ACR_CTS_AVERAGE_EN
  localparam int LP_SW = CTS_WIDTH + 2;

  // Three stored windows plus the live measurement form the 4-entry average.
  logic [CTS_WIDTH-1:0] r_hist [0:2];
  logic [1:0]           r_hist_cnt;
  logic [LP_SW-1:0]     w_sum;
  logic                 w_push;

  assign w_push      = w_wrap && !w_rate_chg && (r_state != ST_IDLE);
  assign w_sum       = LP_SW'(r_hist[0]) + LP_SW'(r_hist[1]) + LP_SW'(r_hist[2])
                     + LP_SW'(w_meas) + LP_SW'(2);
  assign w_load_cts  = w_sum[LP_SW-1:2];
  assign w_hist_full = (r_hist_cnt == 2'd3);

  always_ff @(posedge clk_pixel) begin
    if (!reset_n || w_rate_chg || w_timeout) begin
      r_hist     <= '{default: '0};
      r_hist_cnt <= 2'd0;
    end else if (w_push) begin
      r_hist[0] <= w_meas;
      r_hist[1] <= r_hist[0];
      r_hist[2] <= r_hist[1];
      if (r_hist_cnt != 2'd3) begin
        r_hist_cnt <= r_hist_cnt + 2'd1;
      end
    end
  end
`else
  assign w_load_cts  = w_meas;
  assign w_hist_full = 1'b1;
`endif

  assign w_load = w_wrap && !w_rate_chg &&
                  ((r_state == ST_LOCKED) || ((r_state == ST_MEASURE) && w_hist_full));

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_rate    <= RATE_48K;
      r_n       <= N_TABLE[RATE_48K];
      r_pkt_n   <= N_TABLE[RATE_48K];
      r_cts     <= '0;
      r_pending <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_rate <= rate_sel;
      r_n    <= N_TABLE[rate_sel];
      if (w_rate_chg) begin
        r_state   <= ST_IDLE;
        r_locked  <= 1'b0;
        r_pending <= 1'b0;
      end else begin
        if (packet_ack && r_pending) begin
          r_pending <= 1'b0;
        end
        // A load in the same cycle as an ack wins: the new packet stays pending.
        if (w_load) begin
          r_cts     <= w_load_cts;
          r_pkt_n   <= r_n;
          r_pending <= 1'b1;
        end
        if (w_timeout) begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end else if (w_wrap) begin
          case (r_state)
            ST_IDLE: r_state <= ST_MEASURE;
            ST_MEASURE: begin
              if (w_hist_full) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end
            ST_LOCKED: r_locked <= 1'b1;
            default: begin
              r_state  <= ST_IDLE;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign packet_ready = r_pending;
  assign locked       = r_locked;
  assign n_value      = r_n;
  assign cts_value    = 20'(r_cts);
  assign header       = ACR_HEADER;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sub[i] = acr_subpacket(r_pkt_n, cts_value);
    end
  end

  property p_cts_range;
    @(posedge clk_pixel) disable iff (!reset_n)
      w_load |-> ((64'(w_load_cts) < (64'd1 << CTS_WIDTH)) && (64'(w_load_cts) <= 64'(VIDEO_RATE)));
  endproperty
  a_cts_range: assert property (p_cts_range);

endmodule
